forward_hazard_unit: RTL



---
 rtl/forward_hazard_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/forward_hazard_unit.sv
// ALU operand forwarding selects plus load-use stall FSM with a saturating hazard counter.
// Forwarding and stall controls are combinational; FSM and counter update on the rising edge.
module forward_hazard_unit #(
  parameter int ADDR_W       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] IFID_Rs,
  input  logic [ADDR_W-1:0] IFID_Rt,
  input  logic [ADDR_W-1:0] IDEX_Rs,
  input  logic [ADDR_W-1:0] IDEX_Rt,
  input  logic              IDEX_MemRead,
  input  logic [ADDR_W-1:0] IDEX_WriteRegister,
  input  logic              EXMEM_RegWrite,
  input  logic              MEMWB_RegWrite,
  input  logic [ADDR_W-1:0] EXMEM_WriteRegister,
  input  logic [ADDR_W-1:0] MEMWB_WriteRegister,
  input  logic              cnt_clear,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              Stall_PC,
  output logic              Stall_IFID,
  output logic              Flush_IDEX,
  output logic              stall_busy,
  output logic [CNT_W-1:0]  hazard_count
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_STALL  = 1'b1;
  localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);

  logic             state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             detect;
  logic             hz_evt;
  logic             stall;

  // EX/MEM is checked first so the youngest producer wins; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic              ex_we,
    input logic [ADDR_W-1:0] ex_wr,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_wr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_we && (ex_wr != '0) && (ex_wr == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_wr != '0) && (wb_wr == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardA = fwd_sel(IDEX_Rs, EXMEM_RegWrite, EXMEM_WriteRegister,
                            MEMWB_RegWrite, MEMWB_WriteRegister);
  assign ForwardB = fwd_sel(IDEX_Rt, EXMEM_RegWrite, EXMEM_WriteRegister,
                            MEMWB_RegWrite, MEMWB_WriteRegister);

  assign detect = IDEX_MemRead && (IDEX_WriteRegister != '0) &&
                  ((IDEX_WriteRegister == IFID_Rs) || (IDEX_WriteRegister == IFID_Rt));

  assign hz_evt = (state_q == S_IDLE) && detect;

  // Gated by reset so a hazard visible during reset cannot freeze the pipeline.
  assign stall        = reset && (hz_evt || (state_q == S_STALL));
  assign Stall_PC     = stall;
  assign Stall_IFID   = stall;
  assign Flush_IDEX   = stall;
  assign stall_busy   = reset && (state_q == S_STALL);
  assign hazard_count = cnt_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (detect && (STALL_CYCLES > 1)) begin
          state_d = S_STALL;
          rem_d   = REM_INIT;
        end
      end
      default: begin
        rem_d = rem_q - 3'd1;
        if (rem_q <= 3'd1) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (hz_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
